bus_xfer_ctrl: RTL and testbench

- Sequencer for the shared 4-bit register bus: turns register-transfer commands into registered one-hot Rout/Rin strobes for the register file.
- Supports MOVE (src->dst, 1 bus cycle) and SWAP (a<->b through temp register T = NREG-1, 3 bus cycles).
- Guarantees at most one bus driver per cycle.
- Sits between the instruction/control logic and the register file + bus (top_level datapath).

---
 rtl/bus_xfer_ctrl_pkg.sv | 23 ++
 rtl/bus_xfer_ctrl_idx_onehot.sv | 17 +
 rtl/bus_xfer_ctrl.sv | 147 ++++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared encodings and default sizing for the register-bus transfer sequencer.
package bus_xfer_pkg;

  localparam int NREG_DEF = 4;
  localparam int IDXW_DEF = 2;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_MOVE = 2'b01,
    OP_SWAP = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_X1   = 3'd1,
    ST_X2   = 3'd2,
    ST_X3   = 3'd3,
    ST_FIN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/bus_xfer_ctrl_idx_onehot.sv
// Register index to one-hot strobe decoder; indices with no matching register decode to zero.
module idx_onehot #(
  parameter int NREG = 4,
  parameter int IDXW = 2
) (
  input  logic            en,
  input  logic [IDXW-1:0] idx,
  output logic [NREG-1:0] onehot
);

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == IDXW'(gi));
    end
  endgenerate

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-bus transfer sequencer: MOVE and SWAP (via temp R(NREG-1)) as registered one-hot strobes.
// Optional BUS_XFER_STATS_EN adds a 16-bit count of executed bus cycles (xfer_count).
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [IDXW-1:0] cmd_src,
  input  logic [IDXW-1:0] cmd_dst,
  output logic [NREG-1:0] reg_out,
  output logic [NREG-1:0] reg_in,
  output logic            busy,
  output logic            done,
  output logic            err
`ifdef BUS_XFER_STATS_EN
  ,output logic [15:0]    xfer_count
`endif
);

  localparam logic [IDXW-1:0] T_IDX  = IDXW'(NREG - 1);
  localparam logic [IDXW:0]   NREG_W = (IDXW + 1)'(NREG);

  state_e          state_reg, state_next;
  op_e             op_reg, op_eff;
  logic [IDXW-1:0] src_reg, dst_reg, src_eff, dst_eff, out_idx, in_idx;
  logic            accept, cmd_bad, range_bad, xfer_en;
  logic [NREG-1:0] out_oh, in_oh;
  logic [NREG-1:0] reg_out_reg, reg_in_reg;
  logic            ready_reg, busy_reg, done_reg, err_reg;

  always_comb begin
    accept    = cmd_valid && ready_reg;
    // On the accept edge the strobes for X1 come straight from the command inputs.
    op_eff    = accept ? op_e'(cmd_op) : op_reg;
    src_eff   = accept ? cmd_src : src_reg;
    dst_eff   = accept ? cmd_dst : dst_reg;
    range_bad = ({1'b0, cmd_src} >= NREG_W) || ({1'b0, cmd_dst} >= NREG_W);

    cmd_bad = 1'b0;
    case (op_e'(cmd_op))
      OP_MOVE: cmd_bad = range_bad || (cmd_src == cmd_dst);
      OP_SWAP: cmd_bad = range_bad || (cmd_src == cmd_dst) ||
                         (cmd_src == T_IDX) || (cmd_dst == T_IDX);
      OP_RSVD: cmd_bad = 1'b1;
      default: cmd_bad = 1'b0;
    endcase

    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_bad)                         state_next = ST_ERR;
          else if (op_e'(cmd_op) == OP_NOP)    state_next = ST_FIN;
          else                                 state_next = ST_X1;
        end
      end
      ST_X1:   state_next = (op_reg == OP_SWAP) ? ST_X2 : ST_FIN;
      ST_X2:   state_next = ST_X3;
      ST_X3:   state_next = ST_FIN;
      default: state_next = ST_IDLE;
    endcase

    xfer_en = state_next inside {ST_X1, ST_X2, ST_X3};
    out_idx = src_eff;
    in_idx  = dst_eff;
    case (state_next)
      ST_X1: if (op_eff == OP_SWAP) in_idx = T_IDX;
      ST_X2: begin
        out_idx = dst_eff;
        in_idx  = src_eff;
      end
      ST_X3: begin
        out_idx = T_IDX;
        in_idx  = dst_eff;
      end
      default: ;
    endcase
  end

  idx_onehot #(.NREG(NREG), .IDXW(IDXW)) u_out_dec (
    .en     (xfer_en),
    .idx    (out_idx),
    .onehot (out_oh)
  );

  idx_onehot #(.NREG(NREG), .IDXW(IDXW)) u_in_dec (
    .en     (xfer_en),
    .idx    (in_idx),
    .onehot (in_oh)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_NOP;
      src_reg     <= '0;
      dst_reg     <= '0;
      reg_out_reg <= '0;
      reg_in_reg  <= '0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      if (accept) begin
        op_reg  <= op_e'(cmd_op);
        src_reg <= cmd_src;
        dst_reg <= cmd_dst;
      end
      reg_out_reg <= out_oh;
      reg_in_reg  <= in_oh;
      ready_reg   <= (state_next == ST_IDLE);
      busy_reg    <= (state_next != ST_IDLE);
      done_reg    <= (state_next == ST_FIN);
      err_reg     <= (state_next == ST_ERR);
    end
  end

  assign cmd_ready = ready_reg;
  assign reg_out   = reg_out_reg;
  assign reg_in    = reg_in_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

`ifdef BUS_XFER_STATS_EN
  logic [15:0] xfer_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_count_reg <= '0;
    end else if (state_reg inside {ST_X1, ST_X2, ST_X3}) begin
      xfer_count_reg <= xfer_count_reg + 16'd1;
    end
  end

  assign xfer_count = xfer_count_reg;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: per-cycle command-level model plus directed literal checks.
// Define BUS_XFER_STATS_EN to also exercise xfer_count.
module tb_bus_xfer_ctrl;

  localparam int NREG = 4;
  localparam int T    = NREG - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0, cmd_src = 2'd0, cmd_dst = 2'd0;
  logic       cmd_ready, busy, done, err;
  logic [3:0] reg_out, reg_in;
`ifdef BUS_XFER_STATS_EN
  logic [15:0] xfer_count;
`endif

  int tests = 0, fails = 0;
  int m_tests = 0, m_fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bus_xfer_ctrl #(.NREG(NREG), .IDXW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .reg_out   (reg_out),
    .reg_in    (reg_in),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef BUS_XFER_STATS_EN
    ,.xfer_count (xfer_count)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- command-level model ----------------
  typedef struct packed {
    logic [3:0] o;
    logic [3:0] i;
    logic       b;
    logic       d;
    logic       e;
    logic       r;
  } obs_t;

  obs_t        exp_q[$];
  logic [15:0] model_inc  = 16'd0;
  logic [15:0] model_base = 16'd0;

  function automatic logic [3:0] oh(input int k);
    logic [3:0] v;
    v = 4'd0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic obs_t mk(input logic [3:0] o, input logic [3:0] i,
                              input logic b, input logic d, input logic e);
    obs_t v;
    v.o = o; v.i = i; v.b = b; v.d = d; v.e = e; v.r = 1'b0;
    return v;
  endfunction

  function automatic bit bad_cmd(input int op, input int a, input int b);
    if (op == 3) return 1'b1;
    if (op == 0) return 1'b0;
    if (a >= NREG || b >= NREG || a == b) return 1'b1;
    if (op == 2 && (a == T || b == T)) return 1'b1;
    return 1'b0;
  endfunction

  // Expected per-cycle outputs for the cycles following an accept.
  task automatic plan(input logic [1:0] op, input logic [1:0] s, input logic [1:0] d);
    int a, b;
    a = int'(s);
    b = int'(d);
    if (bad_cmd(int'(op), a, b)) begin
      exp_q.push_back(mk(4'd0, 4'd0, 1'b1, 1'b0, 1'b1));
    end else begin
      if (op == 2'd1) begin
        exp_q.push_back(mk(oh(a), oh(b), 1'b1, 1'b0, 1'b0));
      end else if (op == 2'd2) begin
        exp_q.push_back(mk(oh(a), oh(T), 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(oh(b), oh(a), 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(oh(T), oh(b), 1'b1, 1'b0, 1'b0));
      end
      exp_q.push_back(mk(4'd0, 4'd0, 1'b1, 1'b1, 1'b0));
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      model_inc <= 16'd0;
    end else if (exp_q.size() != 0) begin
      if (exp_q[0].o != 4'd0) model_inc <= model_inc + 16'd1;
      void'(exp_q.pop_front());
    end else if (cmd_valid) begin
      plan(cmd_op, cmd_src, cmd_dst);
    end
  end

  always @(negedge clk) begin
    obs_t e, a;
    if (rst && chk_en) begin
      if (exp_q.size() != 0) e = exp_q[0];
      else                   e = mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      e.r = (exp_q.size() == 0);
      a = {reg_out, reg_in, busy, done, err, cmd_ready};
      m_tests++;
      if (a !== e) begin
        m_fails++;
        $display("FAIL model cyc=%0d got out/in=%b/%b busy=%b done=%b err=%b rdy=%b required out/in=%b/%b busy=%b done=%b err=%b rdy=%b",
                 cyc, a.o, a.i, a.b, a.d, a.e, a.r, e.o, e.i, e.b, e.d, e.e, e.r);
      end
      m_tests++;
      if ($countones(reg_out) > 1 || $countones(reg_in) > 1 || (reg_out & reg_in) != 4'd0 ||
          (reg_in == 4'd0 && reg_out != 4'd0) || (done && err)) begin
        m_fails++;
        $display("FAIL invariant cyc=%0d got out=%b in=%b done=%b err=%b", cyc, reg_out, reg_in, done, err);
      end
`ifdef BUS_XFER_STATS_EN
      m_tests++;
      if (xfer_count !== 16'(model_base + model_inc)) begin
        m_fails++;
        $display("FAIL xfer_count cyc=%0d got %h required %h", cyc, xfer_count, 16'(model_base + model_inc));
      end
`endif
    end
  end

  // ---------------- directed checks ----------------
  logic [3:0] rf[NREG];
  int         acc_cyc, done_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int k = 0; k < NREG; k++) if (v[k]) return k;
    return 0;
  endfunction

  // Advance to the middle of the next cycle and apply that cycle's bus transfer to rf.
  task automatic step();
    @(negedge clk);
    if (reg_out != 4'd0 && reg_in != 4'd0) rf[oh2i(reg_in)] = rf[oh2i(reg_out)];
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] s, input logic [1:0] d, input bit keep);
    bit got;
    got = 1'b0;
    cmd_op = op; cmd_src = s; cmd_dst = d; cmd_valid = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc_cyc = cyc;
        got = 1'b1;
      end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_op  = 2'($urandom_range(3));
      cmd_src = 2'($urandom_range(3));
      cmd_dst = 2'($urandom_range(3));
    end
  endtask

  initial begin
    rf[0] = 4'hA; rf[1] = 4'h5; rf[2] = 4'h0; rf[3] = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {24'd0, reg_out, reg_in}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // MOVE R0->R1
    send(2'd1, 2'd0, 2'd1, 1'b0);
    step();
    chk("move_strobe", {24'd0, reg_out, reg_in}, 32'h12);
    step();
    chk("move_done", {30'd0, busy, done}, 32'd3);
    chk("move_data", {28'd0, rf[1]}, 32'hA);

    // SWAP R1,R2
    rf[1] = 4'h3; rf[2] = 4'hC;
    send(2'd2, 2'd1, 2'd2, 1'b0);
    step(); chk("swap_c1", {24'd0, reg_out, reg_in}, 32'h28);
    step(); chk("swap_c2", {24'd0, reg_out, reg_in}, 32'h42);
    step(); chk("swap_c3", {24'd0, reg_out, reg_in}, 32'h84);
    step(); chk("swap_done", {31'd0, done}, 32'd1);
    chk("swap_r1", {28'd0, rf[1]}, 32'hC);
    chk("swap_r2", {28'd0, rf[2]}, 32'h3);

    // NOP and reserved op
    send(2'd0, 2'd0, 2'd0, 1'b0);
    step(); chk("nop_done", {29'd0, busy, done, err}, 32'd6);
    send(2'd3, 2'd0, 2'd1, 1'b0);
    step(); chk("rsvd_err", {21'd0, reg_out, reg_in, busy, done, err}, 32'h5);
`ifdef BUS_XFER_STATS_EN
    step(); chk("stats_four", {16'd0, xfer_count}, 32'd4);
`endif
    send(2'd1, 2'd2, 2'd2, 1'b0);
    step(); chk("move_same_err", {21'd0, reg_out, reg_in, busy, done, err}, 32'h5);
    send(2'd2, 2'd0, 2'd3, 1'b0);
    step(); chk("swap_t_err", {21'd0, reg_out, reg_in, busy, done, err}, 32'h5);

    // Back-to-back with valid held
    send(2'd1, 2'd0, 2'd2, 1'b1);
    cmd_op = 2'd2; cmd_src = 2'd0; cmd_dst = 2'd1;
    done_cyc = -100;
    for (int n = 0; n < 8 && done_cyc < 0; n++) begin
      step();
      if (done) done_cyc = cyc;
    end
    send(2'd2, 2'd0, 2'd1, 1'b0);
    chk("b2b_gap", 32'(acc_cyc - done_cyc), 32'd1);
    repeat (4) step();

    // Reset in X2 of a SWAP
    send(2'd2, 2'd0, 2'd1, 1'b0);
    step();
    step();
    chk("x2_before_rst", {24'd0, reg_out, reg_in}, 32'h21);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_outs", {23'd0, reg_out, reg_in, busy}, 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_mid_nodone", {31'd0, done}, 32'd0);
    end
    #1 rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_rst_nodone", {31'd0, done}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

`ifdef BUS_XFER_STATS_EN
    #1;
    dut.xfer_count_reg = 16'hFFFF;
    model_base = 16'hFFFF - model_inc;
    send(2'd1, 2'd1, 2'd0, 1'b0);
    step();
    step();
    chk("stats_wrap", {16'd0, xfer_count}, 32'd0);
`endif

    step();
    chk_en = 1'b0;
    @(negedge clk);
    tests = tests + m_tests;
    fails = fails + m_fails;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
